alu_cmd_seq: RTL and testbench
==============================

Name: alu_cmd_seq

Overview:
Sequential command front-end for the team's 8-bit combinational ALU (5-bit opcode, 8-bit Z, carry/borrow out).
- Accepts operation commands over a valid/ready handshake.
- Drives the ALU operand/select inputs from registers, waits a programmable settle time, then captures Z/Cout.
- Returns results over a second valid/ready handshake.
- Holds an 8-bit accumulator so that chained operations can use the previous result as operand A.

Parameters:
SETTLE_CYCLES, 1, cycles ALU inputs are held stable before sampling; legal range 1..15.
ACC_RESET, 8'h00, accumulator value after reset.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  sequencer can accept a command.
cmd_op  in  5  ALU opcode.
cmd_a  in  8  operand A; ignored when cmd_use_acc=1.
cmd_b  in  8  operand B.
cmd_use_acc  in  1  use accumulator as operand A.
cmd_wb  in  1  write the result into the accumulator.
rsp_valid  out  1  result available.
rsp_ready  in  1  consumer accepts the result.
rsp_z  out  8  captured result.
rsp_cout  out  1  captured carry/borrow.
rsp_err  out  1  opcode illegal (>5'h08).
alu_a  out  8  to ALU A.
alu_b  out  8  to ALU B.
alu_sel  out  5  to ALU SEL.
alu_z  in  8  from ALU Z.
alu_cout  in  1  from ALU Cout.
acc  out  8  accumulator contents.

Behaviour:
- Opcode map (fixed):
  - 00 = A, 01 = B, 02 = AND, 03 = OR, 04 = A-B, 05 = A+B, 06 = A+1, 07 = A+B+1, 08 = A-B-1.
  - Others are illegal.
  - Arithmetic is 9-bit {Cout,Z}; subtract Cout = 1 on borrow (two's-complement bit 8).
- Cout masking:
  - ALU Cout is not defined for opcodes 00/01 or illegal codes, so rsp_cout is forced to 0 for those.
  - For 02/03 it is 0 by construction; it is captured as-is.
- Reset (async, rst_n=0):
  - state=IDLE, cmd_ready=0 while in reset.
  - rsp_valid=0, rsp_z=0, rsp_cout=0, rsp_err=0.
  - alu_a=alu_b=0, alu_sel=0, acc=ACC_RESET, settle counter=0.
  - Any in-flight command is dropped; no response is produced for it.
- FSM states: IDLE, SETTLE, RESP.
  - IDLE:
    - cmd_ready=1.
    - On an edge with cmd_valid&cmd_ready: alu_a <= (cmd_use_acc ? acc : cmd_a), alu_b <= cmd_b, alu_sel <= cmd_op (illegal ops drive 5'h00).
    - Latch op/wb/err; counter <= SETTLE_CYCLES-1; go to SETTLE.
  - SETTLE:
    - cmd_ready=0; ALU inputs held constant.
    - While counter != 0, decrement.
    - When counter == 0, on that edge: capture rsp_z <= (err ? 0 : alu_z), rsp_cout <= masked alu_cout, rsp_err <= err, rsp_valid <= 1.
    - If wb & !err, acc <= alu_z. Go to RESP.
  - RESP:
    - rsp_* held stable while rsp_valid=1 & !rsp_ready; cmd_ready=0.
    - On an edge with rsp_ready=1: rsp_valid <= 0, go to IDLE.
    - rsp_z/rsp_cout/rsp_err keep their last values after the handshake.
- Latency:
  - Command accepted at edge T; rsp_valid rises after edge T+SETTLE_CYCLES.
  - Earliest next accept is the edge after the response handshake (no overlap).
  - Throughput with SETTLE=1 and rsp_ready tied high: one command per 3 cycles.
- cmd_ready is a combinational decode of state==IDLE only; it does not depend on cmd_valid.
- Accumulator:
  - cmd_use_acc samples acc at accept, so it reflects every earlier write-back.
  - acc changes only at capture, and only when wb=1 and the op is legal.
- alu_a/alu_b/alu_sel keep their values after capture until the next accept (no toggling on idle).
- Opcode 06 ignores B; the sequencer still drives B as given.
- Inputs cmd_* are don't-care when cmd_valid=0.
- rsp_ready is don't-care outside RESP.

Test Plan:
- Reset: rst_n low mid-SETTLE of an ADD -> all outputs 0, acc=ACC_RESET, state IDLE; no rsp_valid after release.
- ADD: op=05, a=F0, b=20, SETTLE=1, rsp_ready=1 -> rsp_valid after accept edge+1, rsp_z=10, rsp_cout=1.
- SUB: op=04, a=05, b=07 -> rsp_z=FE, rsp_cout=1.
- SUB-1: op=08, a=10, b=05 -> rsp_z=0A, rsp_cout=0.
- Accumulate chain:
  - op=06, a=FF, wb=1 -> rsp_z=00, cout=1, acc=00.
  - Then op=05, use_acc=1, b=33, wb=1 -> rsp_z=33, acc=33.
- Cout mask and backpressure:
  - op=00 with alu_cout forced 1 -> rsp_cout=0.
  - Hold rsp_ready=0 for 5 cycles -> rsp_* stable, cmd_ready=0; handshake then returns to IDLE.
- Illegal op and settle:
  - op=1F, wb=1 -> alu_sel=00, rsp_err=1, rsp_z=00, rsp_cout=0, acc unchanged.
  - SETTLE_CYCLES=4 -> rsp_valid exactly 4 edges after accept.

Source files
------------

// File: rtl/alu_cmd_seq.sv
// Valid/ready command sequencer for the 8-bit combinational ALU: registers operands,
// waits SETTLE_CYCLES, captures Z/Cout into a response register and optional accumulator.
module alu_cmd_seq #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [7:0]  ACC_RESET     = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [4:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic       cmd_use_acc,
    input  logic       cmd_wb,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_z,
    output logic       rsp_cout,
    output logic       rsp_err,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [4:0] alu_sel,
    input  logic [7:0] alu_z,
    input  logic       alu_cout,
    output logic [7:0] acc
);

    typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

    localparam logic [4:0] OpA     = 5'h00;
    localparam logic [4:0] OpB     = 5'h01;
    localparam logic [4:0] OpMax   = 5'h08;
    localparam logic [3:0] CntInit = 4'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic [4:0] alu_sel_q, alu_sel_d;
    logic       wb_q, wb_d;
    logic       err_q, err_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_z_q, rsp_z_d;
    logic       rsp_cout_q, rsp_cout_d;
    logic       rsp_err_q, rsp_err_d;
    logic [7:0] acc_q, acc_d;
    logic       cmd_illegal;
    logic       cout_masked;

    assign cmd_illegal = (cmd_op > OpMax);
    // Illegal ops were mapped to sel 00 at accept, so the sel test also covers them.
    assign cout_masked = err_q || (alu_sel_q == OpA) || (alu_sel_q == OpB);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        wb_d        = wb_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        rsp_z_d     = rsp_z_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_err_d   = rsp_err_q;
        acc_d       = acc_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    alu_a_d   = cmd_use_acc ? acc_q : cmd_a;
                    alu_b_d   = cmd_b;
                    alu_sel_d = cmd_illegal ? 5'h00 : cmd_op;
                    wb_d      = cmd_wb;
                    err_d     = cmd_illegal;
                    cnt_d     = CntInit;
                    state_d   = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_z_d     = err_q ? 8'h00 : alu_z;
                    rsp_cout_d  = cout_masked ? 1'b0 : alu_cout;
                    rsp_err_d   = err_q;
                    rsp_valid_d = 1'b1;
                    if (wb_q && !err_q) acc_d = alu_z;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            alu_a_q     <= 8'h00;
            alu_b_q     <= 8'h00;
            alu_sel_q   <= 5'h00;
            wb_q        <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_z_q     <= 8'h00;
            rsp_cout_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            acc_q       <= ACC_RESET;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            wb_q        <= wb_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_z_q     <= rsp_z_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_err_q   <= rsp_err_d;
            acc_q       <= acc_d;
        end
    end

    // Held low during reset even though the state register already reads IDLE.
    assign cmd_ready = rst_n && (state_q == StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_err   = rsp_err_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign acc       = acc_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for alu_cmd_seq: two instances (settle 1 and settle 4) each driving a behavioural ALU;
// table-driven commands plus hand-written reset and backpressure sequences.
module tb_alu_cmd_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       which;
    logic       cmd_valid, cmd_use_acc, cmd_wb, rsp_ready, force_cout;
    logic [4:0] cmd_op;
    logic [7:0] cmd_a, cmd_b;

    logic       cmd_ready1, rsp_valid1, rsp_cout1, rsp_err1, alu_cout1;
    logic [7:0] rsp_z1, alu_a1, alu_b1, alu_z1, acc1;
    logic [4:0] alu_sel1;
    logic       cmd_ready4, rsp_valid4, rsp_cout4, rsp_err4, alu_cout4;
    logic [7:0] rsp_z4, alu_a4, alu_b4, alu_z4, acc4;
    logic [4:0] alu_sel4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [4:0] s);
        case (s)
            5'h00:   return {1'b0, a};
            5'h01:   return {1'b0, b};
            5'h02:   return {1'b0, a & b};
            5'h03:   return {1'b0, a | b};
            5'h04:   return {1'b0, a} - {1'b0, b};
            5'h05:   return {1'b0, a} + {1'b0, b};
            5'h06:   return {1'b0, a} + 9'd1;
            5'h07:   return {1'b0, a} + {1'b0, b} + 9'd1;
            5'h08:   return {1'b0, a} - {1'b0, b} - 9'd1;
            default: return 9'h000;
        endcase
    endfunction

    assign {alu_cout1, alu_z1} = alu_model(alu_a1, alu_b1, alu_sel1) | {force_cout, 8'h00};
    assign {alu_cout4, alu_z4} = alu_model(alu_a4, alu_b4, alu_sel4) | {force_cout, 8'h00};

    alu_cmd_seq #(.SETTLE_CYCLES(1), .ACC_RESET(8'h00)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid & ~which), .cmd_ready(cmd_ready1),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_use_acc(cmd_use_acc), .cmd_wb(cmd_wb),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready & ~which),
        .rsp_z(rsp_z1), .rsp_cout(rsp_cout1), .rsp_err(rsp_err1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1),
        .alu_z(alu_z1), .alu_cout(alu_cout1), .acc(acc1)
    );

    alu_cmd_seq #(.SETTLE_CYCLES(4), .ACC_RESET(8'hA5)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid & which), .cmd_ready(cmd_ready4),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_use_acc(cmd_use_acc), .cmd_wb(cmd_wb),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready & which),
        .rsp_z(rsp_z4), .rsp_cout(rsp_cout4), .rsp_err(rsp_err4),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_sel(alu_sel4),
        .alu_z(alu_z4), .alu_cout(alu_cout4), .acc(acc4)
    );

    logic       v_cmd_ready, v_rsp_valid, v_rsp_cout, v_rsp_err;
    logic [7:0] v_rsp_z, v_alu_a, v_alu_b, v_acc;
    logic [4:0] v_alu_sel;
    assign v_cmd_ready = which ? cmd_ready4 : cmd_ready1;
    assign v_rsp_valid = which ? rsp_valid4 : rsp_valid1;
    assign v_rsp_cout  = which ? rsp_cout4  : rsp_cout1;
    assign v_rsp_err   = which ? rsp_err4   : rsp_err1;
    assign v_rsp_z     = which ? rsp_z4     : rsp_z1;
    assign v_alu_a     = which ? alu_a4     : alu_a1;
    assign v_alu_b     = which ? alu_b4     : alu_b1;
    assign v_alu_sel   = which ? alu_sel4   : alu_sel1;
    assign v_acc       = which ? acc4       : acc1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issues one command, checks settle behaviour, latency and response, optionally stalls.
    task automatic run_cmd(input logic w, input logic [4:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic ua, input logic wb,
                           input logic [7:0] ea, input logic [7:0] ez, input logic ec,
                           input logic ee, input logic [7:0] eacc, input int hold);
        int lat;
        logic [4:0] esel;
        esel  = (op > 5'h08) ? 5'h00 : op;
        which = w;
        @(negedge clk);
        chk("idle_ready", v_cmd_ready, 1);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_wb = wb; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_a = ~a; cmd_b = ~b; cmd_op = 5'h1E;
        @(negedge clk);
        chk("settle_state", {v_rsp_valid, v_cmd_ready}, 2'b00);
        chk("alu_drive", {v_alu_a, v_alu_b, v_alu_sel}, {ea, b, esel});
        lat = 0;
        while (!v_rsp_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", lat, w ? 4 : 1);
        chk("rsp_z", v_rsp_z, ez);
        chk("rsp_cout_err", {v_rsp_cout, v_rsp_err}, {ec, ee});
        chk("acc", v_acc, eacc);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_stable", {v_rsp_valid, v_rsp_z, v_rsp_cout, v_rsp_err, v_cmd_ready},
                {1'b1, ez, ec, ee, 1'b0});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("post_hs", {v_rsp_valid, v_cmd_ready, v_rsp_z, v_alu_a}, {1'b0, 1'b1, ez, ea});
    endtask

    typedef struct {
        logic [4:0] op;
        logic [7:0] a, b;
        logic       ua, wb;
        logic [7:0] z;
        logic       c, e;
        logic [7:0] acc;
    } vec_t;

    vec_t       vecs[14];
    logic [7:0] model_acc;
    logic       seen;

    initial begin
        vecs[0]  = '{5'h05, 8'hF0, 8'h20, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 8'h00};
        vecs[1]  = '{5'h04, 8'h05, 8'h07, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0, 8'h00};
        vecs[2]  = '{5'h08, 8'h10, 8'h05, 1'b0, 1'b0, 8'h0A, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{5'h01, 8'h00, 8'h77, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 8'h77};
        vecs[4]  = '{5'h06, 8'hFF, 8'h12, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};
        vecs[5]  = '{5'h05, 8'hAA, 8'h33, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 8'h33};
        vecs[6]  = '{5'h07, 8'hAA, 8'h01, 1'b1, 1'b0, 8'h35, 1'b0, 1'b0, 8'h33};
        vecs[7]  = '{5'h02, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 8'h33};
        vecs[8]  = '{5'h03, 8'hF0, 8'h0C, 1'b0, 1'b0, 8'hFC, 1'b0, 1'b0, 8'h33};
        vecs[9]  = '{5'h00, 8'h5C, 8'h99, 1'b0, 1'b0, 8'h5C, 1'b0, 1'b0, 8'h33};
        vecs[10] = '{5'h1F, 8'h12, 8'h34, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h33};
        vecs[11] = '{5'h09, 8'h12, 8'h34, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'h33};
        vecs[12] = '{5'h04, 8'h00, 8'h33, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h33};
        vecs[13] = '{5'h04, 8'h00, 8'h34, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 8'hFF};

        rst_n = 1'b0; which = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; force_cout = 1'b0;
        cmd_op = 5'h00; cmd_a = 8'h00; cmd_b = 8'h00; cmd_use_acc = 1'b0; cmd_wb = 1'b0;
        #12;
        chk("rst_ready", {cmd_ready1, cmd_ready4}, 2'b00);
        chk("rst_rsp", {rsp_valid1, rsp_z1, rsp_cout1, rsp_err1}, 11'h000);
        chk("rst_alu", {alu_a1, alu_b1, alu_sel1}, 21'h0);
        chk("rst_acc", {acc1, acc4}, 16'h00A5);
        @(negedge clk);
        rst_n = 1'b1;

        model_acc = 8'h00;
        for (int i = 0; i < 14; i++) begin
            run_cmd(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ua, vecs[i].wb,
                    vecs[i].ua ? model_acc : vecs[i].a, vecs[i].z, vecs[i].c, vecs[i].e,
                    vecs[i].acc, 0);
            model_acc = vecs[i].acc;
        end

        // Cout forced high on a pass-through op must be masked; also stall the consumer.
        force_cout = 1'b1;
        run_cmd(1'b0, 5'h00, 8'h12, 8'h34, 1'b0, 1'b0, 8'h12, 8'h12, 1'b0, 1'b0, 8'hFF, 5);
        force_cout = 1'b0;

        // Four-cycle settle instance, accumulating from its reset value.
        run_cmd(1'b1, 5'h05, 8'h00, 8'h01, 1'b1, 1'b1, 8'hA5, 8'hA6, 1'b0, 1'b0, 8'hA6, 2);

        // Reset mid-SETTLE: the in-flight ADD must vanish without a response.
        which = 1'b1;
        @(negedge clk);
        cmd_op = 5'h05; cmd_a = 8'h11; cmd_b = 8'h22; cmd_use_acc = 1'b0; cmd_wb = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_settle_alu", {alu_a4, alu_b4}, 16'h1122);
        rst_n = 1'b0;
        #1;
        chk("rst2_ready", cmd_ready4, 0);
        chk("rst2_rsp", {rsp_valid4, rsp_z4, rsp_cout4, rsp_err4}, 11'h000);
        chk("rst2_alu", {alu_a4, alu_b4, alu_sel4}, 21'h0);
        chk("rst2_acc", {acc4, acc1}, 16'hA500);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid4) seen = 1'b1;
        end
        chk("no_rsp_after_rst", seen, 0);
        chk("idle_after_rst", cmd_ready4, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
